// File: rtl/timer_ctrl.sv
// timer_ctrl: register block and per-channel run sequencer for the
// two-channel timer_counter datapath. Holds LOAD/CMP/mode per channel,
// sequences enable through IDLE/RUN/RESTART, and latches done pulses
// into a sticky, maskable interrupt status.

// Per-channel run sequencer. en is registered alongside the state so the
// counter sees a clean, glitch-free enable; busy mirrors state != IDLE
// for the CTRL start-bit readback.
module timer_ctrl_chan (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic stop,
    input  logic done,
    input  logic oneshot,
    output logic en,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RESTART = 2'd2
    } state_t;

    state_t state;

    // State register with registered en/busy; stop wins over start and done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            en    <= 1'b0;
            busy  <= 1'b0;
        end else if (stop) begin
            state <= IDLE;
            en    <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        en    <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    // A start alongside a one-shot done still restarts.
                    if (start) begin
                        state <= RESTART;
                        en    <= 1'b0;
                    end else if (done && oneshot) begin
                        state <= IDLE;
                        en    <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                RESTART: begin
                    // One cycle with en low lets the counter reload.
                    state <= RUN;
                    en    <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    en    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

module timer_ctrl #(
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [CNT_W-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [CNT_W-1:0]  o_rd_data,
    output logic              o_rd_valid,
    output logic              o_cnt0_en,
    output logic              o_cnt0_reload,
    output logic              o_cnt0_count_up,
    output logic [CNT_W-1:0]  o_cnt0_load_value,
    output logic [CNT_W-1:0]  o_cnt0_compare_value,
    output logic              o_cnt1_en,
    output logic              o_cnt1_reload,
    output logic              o_cnt1_count_up,
    output logic [CNT_W-1:0]  o_cnt1_load_value,
    output logic [CNT_W-1:0]  o_cnt1_compare_value,
    output logic              o_cnt1_src,
    input  logic              i_cnt0_done,
    input  logic              i_cnt1_done,
    output logic              o_irq
);

    localparam int NUM_CH = 2;

    localparam logic [ADDR_W-1:0] A_CTRL0  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_LOAD0  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_CMP0   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_CTRL1  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_LOAD1  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_CMP1   = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] A_MASK   = ADDR_W'(7);

    // CTRL bit positions
    localparam int B_START   = 0;
    localparam int B_STOP    = 1;
    localparam int B_ONESHOT = 2;
    localparam int B_UP      = 3;
    localparam int B_SRC     = 4;

    logic [NUM_CH-1:0][CNT_W-1:0] load_q;
    logic [NUM_CH-1:0][CNT_W-1:0] cmp_q;
    logic [NUM_CH-1:0]            oneshot_q;
    logic [NUM_CH-1:0]            up_q;
    logic                         src_q;
    logic [NUM_CH-1:0]            status_q;
    logic [NUM_CH-1:0]            mask_q;

    logic [NUM_CH-1:0]            wr_ctrl;
    logic [NUM_CH-1:0]            start;
    logic [NUM_CH-1:0]            stop;
    logic [NUM_CH-1:0]            done;
    logic [NUM_CH-1:0]            en;
    logic [NUM_CH-1:0]            busy;
    logic [NUM_CH-1:0]            w1c;
    logic [CNT_W-1:0]             rd_mux;

    assign done = {i_cnt1_done, i_cnt0_done};

    // CTRL write decode: start/stop are pulses taken straight from the write.
    always_comb begin
        wr_ctrl = '0;
        start   = '0;
        stop    = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            wr_ctrl[n] = i_wr_en && (i_wr_addr == ADDR_W'(3 * n));
            start[n]   = wr_ctrl[n] && i_wr_data[B_START];
            stop[n]    = wr_ctrl[n] && i_wr_data[B_STOP];
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
        timer_ctrl_chan u_chan (
            .clk     (clk),
            .rst     (rst),
            .start   (start[n]),
            .stop    (stop[n]),
            .done    (done[n]),
            .oneshot (oneshot_q[n]),
            .en      (en[n]),
            .busy    (busy[n])
        );
    end

    // Channel configuration registers; writes land next cycle in any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_q    <= '0;
            cmp_q     <= '0;
            oneshot_q <= '0;
            up_q      <= '0;
            src_q     <= 1'b0;
            mask_q    <= '0;
        end else if (i_wr_en) begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (wr_ctrl[n]) begin
                    oneshot_q[n] <= i_wr_data[B_ONESHOT];
                    up_q[n]      <= i_wr_data[B_UP];
                end
                if (i_wr_addr == ADDR_W'(3 * n + 1)) load_q[n] <= i_wr_data;
                if (i_wr_addr == ADDR_W'(3 * n + 2)) cmp_q[n]  <= i_wr_data;
            end
            if (wr_ctrl[1]) src_q <= i_wr_data[B_SRC];
            if (i_wr_addr == A_MASK) mask_q <= i_wr_data[NUM_CH-1:0];
        end
    end

    assign w1c = (i_wr_en && i_wr_addr == A_STATUS) ? i_wr_data[NUM_CH-1:0] : '0;

    // Sticky status: a done in the same cycle as its W1C keeps the bit set.
    always_ff @(posedge clk) begin
        if (rst) status_q <= '0;
        else     status_q <= (status_q & ~w1c) | done;
    end

    // Read mux from current (pre-write) register values.
    always_comb begin
        rd_mux = '0;
        case (i_rd_addr)
            A_CTRL0: begin
                rd_mux[B_START]   = busy[0];
                rd_mux[B_ONESHOT] = oneshot_q[0];
                rd_mux[B_UP]      = up_q[0];
            end
            A_LOAD0: rd_mux = load_q[0];
            A_CMP0:  rd_mux = cmp_q[0];
            A_CTRL1: begin
                rd_mux[B_START]   = busy[1];
                rd_mux[B_ONESHOT] = oneshot_q[1];
                rd_mux[B_UP]      = up_q[1];
                rd_mux[B_SRC]     = src_q;
            end
            A_LOAD1:  rd_mux = load_q[1];
            A_CMP1:   rd_mux = cmp_q[1];
            A_STATUS: rd_mux[NUM_CH-1:0] = status_q;
            A_MASK:   rd_mux[NUM_CH-1:0] = mask_q;
            default:  rd_mux = '0;
        endcase
    end

    // Registered read port, one cycle after the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
        end else begin
            o_rd_valid <= i_rd_en;
            if (i_rd_en) o_rd_data <= rd_mux;
        end
    end

    assign o_cnt0_en            = en[0];
    assign o_cnt0_reload        = ~oneshot_q[0];
    assign o_cnt0_count_up      = up_q[0];
    assign o_cnt0_load_value    = load_q[0];
    assign o_cnt0_compare_value = cmp_q[0];
    assign o_cnt1_en            = en[1];
    assign o_cnt1_reload        = ~oneshot_q[1];
    assign o_cnt1_count_up      = up_q[1];
    assign o_cnt1_load_value    = load_q[1];
    assign o_cnt1_compare_value = cmp_q[1];
    assign o_cnt1_src           = src_q;
    assign o_irq                = |(status_q & mask_q);

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: hand-written vector table, directed corner
// sequences, and a randomized run, all cross-checked every cycle against
// a register-level reference model of the controller.
module tb_timer_ctrl;

    localparam int CNT_W  = 32;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_wr_en = 1'b0;
    logic [ADDR_W-1:0] i_wr_addr = '0;
    logic [CNT_W-1:0]  i_wr_data = '0;
    logic              i_rd_en = 1'b0;
    logic [ADDR_W-1:0] i_rd_addr = '0;
    logic [CNT_W-1:0]  o_rd_data;
    logic              o_rd_valid;
    logic              o_cnt0_en, o_cnt0_reload, o_cnt0_count_up;
    logic [CNT_W-1:0]  o_cnt0_load_value, o_cnt0_compare_value;
    logic              o_cnt1_en, o_cnt1_reload, o_cnt1_count_up;
    logic [CNT_W-1:0]  o_cnt1_load_value, o_cnt1_compare_value;
    logic              o_cnt1_src;
    logic              i_cnt0_done = 1'b0;
    logic              i_cnt1_done = 1'b0;
    logic              o_irq;

    always #5 clk = ~clk;

    timer_ctrl #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .o_cnt0_en(o_cnt0_en), .o_cnt0_reload(o_cnt0_reload),
        .o_cnt0_count_up(o_cnt0_count_up), .o_cnt0_load_value(o_cnt0_load_value),
        .o_cnt0_compare_value(o_cnt0_compare_value),
        .o_cnt1_en(o_cnt1_en), .o_cnt1_reload(o_cnt1_reload),
        .o_cnt1_count_up(o_cnt1_count_up), .o_cnt1_load_value(o_cnt1_load_value),
        .o_cnt1_compare_value(o_cnt1_compare_value),
        .o_cnt1_src(o_cnt1_src),
        .i_cnt0_done(i_cnt0_done), .i_cnt1_done(i_cnt1_done),
        .o_irq(o_irq)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: channel run state 0=idle 1=run 2=restart-gap.
    int          m_st[2];
    logic [31:0] m_load[2], m_cmp[2];
    bit          m_os[2], m_up[2];
    bit          m_src;
    bit   [1:0]  m_status, m_mask;
    bit          m_rdv;
    logic [31:0] m_rdd;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input int a);
        case (a)
            0: return 32'(m_st[0] != 0) + 32'(m_os[0]) * 4 + 32'(m_up[0]) * 8;
            1: return m_load[0];
            2: return m_cmp[0];
            3: return 32'(m_st[1] != 0) + 32'(m_os[1]) * 4 + 32'(m_up[1]) * 8 + 32'(m_src) * 16;
            4: return m_load[1];
            5: return m_cmp[1];
            6: return 32'(m_status);
            default: return 32'(m_mask);
        endcase
    endfunction

    task automatic m_reset();
        for (int n = 0; n < 2; n++) begin
            m_st[n] = 0; m_load[n] = 0; m_cmp[n] = 0; m_os[n] = 0; m_up[n] = 0;
        end
        m_src = 0; m_status = 0; m_mask = 0; m_rdv = 0; m_rdd = 0;
    endtask

    // Apply one cycle of inputs, advance the model, compare every output.
    task automatic step(input bit r, input bit we, input int wa, input logic [31:0] wd,
                        input bit re, input int ra, input bit d0, input bit d1);
        int  ns[2];
        bit  dn[2];
        logic [31:0] rd_next;
        rst = r; i_wr_en = we; i_wr_addr = ADDR_W'(wa); i_wr_data = wd;
        i_rd_en = re; i_rd_addr = ADDR_W'(ra); i_cnt0_done = d0; i_cnt1_done = d1;
        dn[0] = d0; dn[1] = d1;
        rd_next = m_read(ra);
        for (int n = 0; n < 2; n++) begin
            bit go   = we && wa == 3 * n && wd[0];
            bit halt = we && wa == 3 * n && wd[1];
            if (halt)              ns[n] = 0;
            else if (m_st[n] == 0) ns[n] = go ? 1 : 0;
            else if (m_st[n] == 2) ns[n] = 1;
            else if (go)           ns[n] = 2;
            else if (dn[n] && m_os[n]) ns[n] = 0;
            else                   ns[n] = 1;
        end
        @(posedge clk);
        #1;
        if (r) m_reset();
        else begin
            m_st[0] = ns[0]; m_st[1] = ns[1];
            if (we && wa == 6) m_status = m_status & ~wd[1:0];
            m_status = m_status | {d1, d0};
            if (we) case (wa)
                0: begin m_os[0] = wd[2]; m_up[0] = wd[3]; end
                1: m_load[0] = wd;
                2: m_cmp[0] = wd;
                3: begin m_os[1] = wd[2]; m_up[1] = wd[3]; m_src = wd[4]; end
                4: m_load[1] = wd;
                5: m_cmp[1] = wd;
                7: m_mask = wd[1:0];
                default: ;
            endcase
            m_rdv = re;
            if (re) m_rdd = rd_next;
        end
        chk("mdl_ctl",
            192'({o_cnt0_en, o_cnt1_en, o_cnt0_reload, o_cnt1_reload, o_cnt0_count_up,
                  o_cnt1_count_up, o_cnt1_src, o_irq, o_rd_valid}),
            192'({m_st[0] == 1, m_st[1] == 1, !m_os[0], !m_os[1], m_up[0], m_up[1],
                  m_src, |(m_status & m_mask), m_rdv}));
        chk("mdl_data",
            {o_cnt0_load_value, o_cnt0_compare_value, o_cnt1_load_value,
             o_cnt1_compare_value, (o_rd_valid ? o_rd_data : 32'h0), 32'h0},
            {m_load[0], m_cmp[0], m_load[1], m_cmp[1], (m_rdv ? m_rdd : 32'h0), 32'h0});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        bit          we;
        int          wa;
        logic [31:0] wd;
        bit          re;
        int          ra;
        bit          d0, d1;
        bit          e0, e1, irq, rv;
        logic [31:0] rd;
    } vec_t;

    vec_t vt[$];

    task automatic add(input bit we, input int wa, input logic [31:0] wd, input bit re,
                       input int ra, input bit d0, input bit d1, input bit e0,
                       input bit e1, input bit irq, input bit rv, input logic [31:0] rd);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.d0 = d0; v.d1 = d1;
        v.e0 = e0; v.e1 = e1; v.irq = irq; v.rv = rv; v.rd = rd;
        vt.push_back(v);
    endtask

    logic [31:0] rb_exp[8];

    initial begin
        //   we wa wd      re ra d0 d1 | e0 e1 irq rv rd
        add(1, 1, 0,      0, 0, 0, 0,  0, 0, 0, 0, 0);   // LOAD0=0
        add(1, 2, 4,      0, 0, 0, 0,  0, 0, 0, 0, 0);   // CMP0=4
        add(1, 0, 32'h9,  0, 0, 0, 0,  1, 0, 0, 0, 0);   // start up -> en0 next cycle
        add(0, 0, 0,      0, 0, 0, 0,  1, 0, 0, 0, 0);
        add(0, 0, 0,      0, 0, 1, 0,  1, 0, 0, 0, 0);   // done0, masked
        add(0, 0, 0,      1, 6, 0, 0,  1, 0, 0, 1, 1);   // STATUS reads 1
        add(1, 7, 1,      0, 0, 0, 0,  1, 0, 1, 0, 0);   // unmask -> irq
        add(1, 6, 1,      0, 0, 1, 0,  1, 0, 1, 0, 0);   // W1C vs done0: stays set
        add(1, 6, 1,      0, 0, 0, 0,  1, 0, 0, 0, 0);   // W1C clears
        add(1, 4, 10,     0, 0, 0, 0,  1, 0, 0, 0, 0);   // LOAD1=10
        add(1, 5, 7,      0, 0, 0, 0,  1, 0, 0, 0, 0);   // CMP1=7
        add(1, 3, 32'h5,  0, 0, 0, 0,  1, 1, 0, 0, 0);   // one-shot start
        add(0, 0, 0,      0, 0, 0, 1,  1, 0, 0, 0, 0);   // done1 -> idle
        add(0, 0, 0,      1, 3, 0, 0,  1, 0, 0, 1, 4);   // CTRL1 start bit 0
        add(1, 0, 32'h9,  0, 0, 0, 0,  0, 0, 0, 0, 0);   // restart gap
        add(0, 0, 0,      0, 0, 0, 0,  1, 0, 0, 0, 0);
        add(1, 0, 32'h2,  0, 0, 0, 0,  0, 0, 0, 0, 0);   // stop
        add(1, 0, 32'h3,  0, 0, 0, 0,  0, 0, 0, 0, 0);   // start+stop from idle
        add(0, 0, 0,      1, 0, 0, 0,  0, 0, 0, 1, 0);
        add(1, 3, 32'h5,  0, 0, 0, 0,  0, 1, 0, 0, 0);
        add(1, 3, 32'h5,  0, 0, 0, 1,  0, 0, 0, 0, 0);   // start beats one-shot done
        add(0, 0, 0,      0, 0, 0, 0,  0, 1, 0, 0, 0);
        add(0, 0, 0,      0, 0, 0, 1,  0, 0, 0, 0, 0);
        add(1, 7, 3,      1, 7, 0, 0,  0, 0, 1, 1, 1);   // read sees pre-write MASK
        add(0, 0, 0,      1, 7, 0, 0,  0, 0, 1, 1, 3);

        m_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_en", 192'({o_cnt0_en, o_cnt1_en}), 192'(0));
        chk("rst_rd_valid", 192'(o_rd_valid), 192'(0));
        chk("rst_irq", 192'(o_irq), 192'(0));
        chk("rst_rd_data", 192'(o_rd_data), 192'(0));
        chk("rst_vals", {o_cnt0_load_value, o_cnt0_compare_value, o_cnt1_load_value,
                         o_cnt1_compare_value, 64'h0}, 192'(0));
        chk("rst_reload", 192'({o_cnt0_reload, o_cnt1_reload}), 192'(2'b11));
        idle(1);

        foreach (vt[i]) begin
            step(0, vt[i].we, vt[i].wa, vt[i].wd, vt[i].re, vt[i].ra, vt[i].d0, vt[i].d1);
            chk($sformatf("tbl%0d_en", i), 192'({o_cnt0_en, o_cnt1_en}), 192'({vt[i].e0, vt[i].e1}));
            chk($sformatf("tbl%0d_irq", i), 192'(o_irq), 192'(vt[i].irq));
            chk($sformatf("tbl%0d_rv", i), 192'(o_rd_valid), 192'(vt[i].rv));
            if (vt[i].rv) chk($sformatf("tbl%0d_rd", i), 192'(o_rd_data), 192'(vt[i].rd));
        end

        // Cascade: channel 1 counts channel-0 dones; done1 on the 4th done0.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 2, 2, 0, 0, 0, 0);
        step(0, 1, 5, 3, 0, 0, 0, 0);
        step(0, 1, 3, 32'h19, 0, 0, 0, 0);
        step(0, 1, 0, 32'h9, 0, 0, 0, 0);
        chk("casc_src", 192'(o_cnt1_src), 192'(1));
        chk("casc_en", 192'({o_cnt0_en, o_cnt1_en}), 192'(2'b11));
        for (int k = 0; k < 4; k++) begin
            idle(2);
            step(0, 0, 0, 0, 0, 0, 1, k == 3);
        end
        step(0, 0, 0, 0, 1, 6, 0, 0);
        chk("casc_status", 192'(o_rd_data), 192'(3));
        step(0, 0, 0, 0, 1, 6, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);        // reset mid-run with a read pending
        chk("midrst_outs", 192'({o_cnt0_en, o_cnt1_en, o_cnt1_src, o_irq, o_rd_valid,
                                 o_cnt0_count_up, o_cnt1_count_up}), 192'(0));

        // Readback of all-ones writes.
        rb_exp = '{32'hC, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1C,
                   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h3};
        for (int a = 0; a < 8; a++) step(0, 1, a, 32'hFFFFFFFF, 0, 0, 0, 0);
        for (int a = 0; a < 8; a++) begin
            step(0, 0, 0, 0, 1, a, 0, 0);
            chk($sformatf("rb%0d_valid", a), 192'(o_rd_valid), 192'(1));
            chk($sformatf("rb%0d_data", a), 192'(o_rd_data), 192'(rb_exp[a]));
            step(0, 0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("rb%0d_valid_drop", a), 192'(o_rd_valid), 192'(0));
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] wd;
            wd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 31));
            step($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7), wd, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
